piece_bag_queue: RTL
====================

# piece_bag_queue

Consumer side of the piece random-number stream. Samples the free-running 3-bit piece ID (1..7) every clock and applies the 7-bag rule: each of the seven tetrominoes is dealt exactly once per bag. Dealt pieces are buffered in a small FIFO that also drives the "next piece" preview. Sits between the piece random-number generator and the game-control FSM, which pops one piece per spawn.

## Interface
- DEPTH, 3: FIFO/preview depth in pieces (1..7).

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rand_in  in  3  raw piece ID from the random generator. 1..7 valid; 0 treated as 1.
- req  in  1  game FSM requests the head piece; pops when piece_valid=1.
- piece_valid  out  1  FIFO non-empty.
- piece_out  out  3  head-of-FIFO piece ID; 0 when empty.
- preview  out  3*DEPTH  FIFO entries, entry k at bits [3k+2:3k], entry 0 = head. Slots at or beyond count read 0.
- bag_mask  out  7  pieces already dealt in the current bag; bit i-1 = piece i.

## Operation
- State: FIFO of DEPTH 3-bit entries, count (0..DEPTH), 7-bit used mask.
- Candidate selection (combinational): c = (rand_in==0) ? 1 : rand_in. If mask[c-1]=0, deal c. Otherwise search upward c+1, c+2, … wrapping 7→1, and deal the first unused ID. An empty mask bit always exists when a push occurs, so the search always terminates.
- pop = req & piece_valid. req while empty is ignored.
- push = (count - pop) < DEPTH, evaluated every cycle. Pop and push in the same cycle are legal, including when full.
- On push:
  - Write the dealt ID at position (count - pop).
  - Set its mask bit.
  - If the mask would become 7'b1111111, clear it to 0 instead (bag complete, new bag starts next cycle).
- On pop: shift entries toward the head; the vacated tail slot is written 0.
- count_next = count + push - pop. It never exceeds DEPTH and never underflows.
- Outputs are registered state only; no combinational path from req or rand_in to any output.

## Timing
- Reset values (cycle after rst sampled high): count=0, mask=0, all FIFO entries 0, piece_valid=0, piece_out=0, preview=0, bag_mask=0.
- rst has priority over push and pop in the same cycle.
- Fill latency:
  - First push on the first clock edge with rst low.
  - piece_valid=1 after that edge.
  - FIFO full DEPTH edges after reset release, with no pops.
- Pop: req sampled high at edge N. piece_out shows the next entry after edge N. A refill into the tail happens at the same edge.
- Continuous req every cycle sustains one piece per cycle indefinitely.
- Bag wrap: the edge dealing the 7th distinct piece leaves bag_mask=0. The next push starts a new bag.
- Reset mid-bag: discards FIFO contents and mask; the next bag starts fresh.

## Test plan
- Fill without pop: reset, rand_in held at 3, req=0 for 5 cycles, DEPTH=3.
  - Required: preview entries = {3,4,5} (head 3), piece_valid=1, bag_mask=7'b0011100.
  - Count stays 3 and mask stays unchanged while full.
- Full bag, one pop per cycle: rand_in held at 5, req=1 continuously.
  - Required: piece_out sequence 5,6,7,1,2,3,4, then 5,6,7,… again.
  - Required: bag_mask returns to 0 exactly on the edge dealing the 7th piece of each bag.
  - Required: no ID repeats within any 7-piece window aligned to a bag.
- Zero input and wrap-around search: rand_in=0 for the first push, then rand_in=7 with mask already holding {1,7}.
  - Required: first deal = 1; second deal = 2 (search wraps 7→1→2).
- Empty and illegal pop: assert req during the reset cycle and the first cycle after release.
  - Required: no underflow; piece_out=0 and piece_valid=0 until the first push.
  - Required: req ignored while empty; count is 1 after the first push edge.
- Simultaneous push/pop when full: FIFO = {2,6,1}, mask with 4 unused, rand_in=4, req=1.
  - Required: after the edge, preview = {6,1,4} and count stays 3.
- Reset mid-operation: after 4 pieces dealt (bag_mask has 4 bits set), pulse rst for 1 cycle.
  - Required: all outputs 0 the next cycle.
  - Required: the following deals start a fresh bag (bag_mask has only 1 bit set after the first push).

Source files
------------

// File: rtl/piece_bag_queue.sv
// piece_bag_queue: 7-bag dealer feeding a small FIFO of upcoming pieces.
// Samples the raw piece ID every cycle. It deals the first piece not yet used in
// the current bag, and keeps the head and preview entries in registers.
module piece_bag_queue #(
  parameter int unsigned DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           rand_in,
  input  logic                 req,
  output logic                 piece_valid,
  output logic [2:0]           piece_out,
  output logic [3*DEPTH-1:0]   preview,
  output logic [6:0]           bag_mask
);

  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned PIECES = 7;

  logic [2:0]       fifo_q [DEPTH];
  logic [2:0]       fifo_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [6:0]       mask_q, mask_d;
  logic             valid_q, valid_d;

  logic [CNT_W-1:0] occ;
  logic             pop, push;
  logic [2:0]       cand, deal, idx;
  logic             found;
  logic [6:0]       mask_set;

  // Deal the first unused ID, searching upward from the sampled one and wrapping 7->1
  always_comb begin
    cand  = (rand_in == 3'd0) ? 3'd1 : rand_in;
    deal  = cand;
    found = 1'b0;
    idx   = 3'd0;
    for (int k = 0; k < int'(PIECES); k++) begin
      idx = 3'((int'(cand) - 1 + k) % int'(PIECES));
      if (!found && !mask_q[idx]) begin
        deal  = idx + 3'd1;
        found = 1'b1;
      end
    end
  end

  // Pop/push decision and next FIFO, count and bag mask
  always_comb begin
    pop      = req & valid_q;
    occ      = count_q - CNT_W'(pop);
    push     = occ < CNT_W'(DEPTH);
    for (int i = 0; i < int'(DEPTH); i++) begin
      fifo_d[i] = fifo_q[i];
    end
    if (pop) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        fifo_d[i] = fifo_q[i+1];
      end
      fifo_d[DEPTH-1] = 3'd0;
    end
    if (push) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (CNT_W'(i) == occ) begin
          fifo_d[i] = deal;
        end
      end
    end
    mask_set = mask_q | (7'd1 << (deal - 3'd1));
    mask_d   = mask_q;
    if (push) begin
      // a completed bag clears immediately so the next push opens a new bag
      mask_d = (mask_set == 7'h7f) ? 7'd0 : mask_set;
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    valid_d = (count_d != '0);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_q[i] <= 3'd0;
      end
      count_q <= '0;
      mask_q  <= 7'd0;
      valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_q[i] <= fifo_d[i];
      end
      count_q <= count_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
    end
  end

  // Pack FIFO entries into the preview bus, head in the low slot
  always_comb begin
    preview = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      preview[3*i +: 3] = fifo_q[i];
    end
  end

  assign piece_out   = fifo_q[0];
  assign piece_valid = valid_q;
  assign bag_mask    = mask_q;

endmodule
